// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the miniALU16: small register file, registered ALU operands,
// settle-window down-counter and a valid/ready response port.
module alu_op_sequencer #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 4,
    parameter int REG_AW   = 2,
    parameter int ALU_WAIT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [REG_AW-1:0] cmd_rd_i,
    input  logic [REG_AW-1:0] cmd_rs1_i,
    input  logic [REG_AW-1:0] cmd_rs2_i,
    input  logic              cmd_imm_en_i,
    input  logic [WIDTH-1:0]  cmd_imm_i,
    output logic [WIDTH-1:0]  alu_in1_o,
    output logic [WIDTH-1:0]  alu_in2_o,
    output logic [1:0]        alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_out_i,
    input  logic              alu_cout_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rsp_cout_o
);

    // state   | meaning
    // IDLE    | cmd_ready high, waiting for a command
    // ISSUE   | operands held on the ALU for ALU_WAIT+1 cycles
    // RESP    | result presented until the consumer takes it
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam int CW = (ALU_WAIT > 0) ? $clog2(ALU_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_WAIT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t            state_q;
    logic [CW-1:0]     wait_cnt_q;
    logic [REG_AW-1:0] rd_q;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  alu_in1_q;
    logic [WIDTH-1:0]  alu_in2_q;
    logic [1:0]        alu_ctrl_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_cout_q;
    logic              rsp_valid_q;

    // Ready is gated by rst so nothing is offered while the block is held in reset.
    assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
    assign alu_in1_o   = alu_in1_q;
    assign alu_in2_o   = alu_in2_q;
    assign alu_ctrl_o  = alu_ctrl_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_cout_o  = rsp_cout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            rd_q        <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_ctrl_q  <= '0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        rd_q <= cmd_rd_i;
                        if (cmd_imm_en_i) begin
                            regs_q[cmd_rd_i] <= cmd_imm_i;
                            rsp_data_q       <= cmd_imm_i;
                            rsp_cout_q       <= 1'b0;
                            rsp_valid_q      <= 1'b1;
                            state_q          <= S_RESP;
                        end else begin
                            // Sources sampled here, so rd==rs sees the pre-write value.
                            alu_in1_q  <= regs_q[cmd_rs1_i];
                            alu_in2_q  <= regs_q[cmd_rs2_i];
                            alu_ctrl_q <= cmd_op_i;
                            wait_cnt_q <= CNT_INIT;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (wait_cnt_q == '0) begin
                        regs_q[rd_q] <= alu_out_i;
                        rsp_data_q   <= alu_out_i;
                        rsp_cout_q   <= alu_cout_i;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_ONE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer using an adder stub as the ALU.
module tb_alu_op_sequencer;

    localparam int WIDTH    = 16;
    localparam int ALU_WAIT = 1;
    localparam int ALU_LAT  = ALU_WAIT + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b1;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [1:0]       cmd_rd = 2'd0;
    logic [1:0]       cmd_rs1 = 2'd0;
    logic [1:0]       cmd_rs2 = 2'd0;
    logic             cmd_imm_en = 1'b0;
    logic [WIDTH-1:0] cmd_imm = '0;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [1:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign {alu_cout, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};

    alu_op_sequencer #(
        .WIDTH(WIDTH), .NREGS(4), .REG_AW(2), .ALU_WAIT(ALU_WAIT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
        .cmd_imm_en_i(cmd_imm_en), .cmd_imm_i(cmd_imm),
        .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_ctrl_o(alu_ctrl),
        .alu_out_i(alu_out), .alu_cout_i(alu_cout),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_cout_o(rsp_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic imm_en, input logic [1:0] op,
                         input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [WIDTH-1:0] imm);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_imm_en = imm_en;
        cmd_op     = op;
        cmd_rd     = rd;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_imm    = imm;
        tick();
        cmd_valid  = 1'b0;
        check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic get_rsp(input string tag, input logic [WIDTH-1:0] exp_data, input logic exp_cout,
                           input int exp_lat, input int lat0, input int hold);
        int lat = lat0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_d"}, 32'(rsp_data), 32'(exp_data));
            check({tag, "_hold_c"}, 32'(rsp_cout), 32'(exp_cout));
            check({tag, "_hold_rdy"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles with a command pending.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", 32'(cmd_ready), 32'd0);
            check("rst_rv", 32'(rsp_valid), 32'd0);
            check("rst_in1", 32'(alu_in1), 32'd0);
            check("rst_in2", 32'(alu_in2), 32'd0);
            check("rst_ctrl", 32'(alu_ctrl), 32'd0);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        tick();
        check("rel_ready", 32'(cmd_ready), 32'd1);
        check("rel_rv", 32'(rsp_valid), 32'd0);

        // Immediate load, then read it back through the ALU with R0 (=0).
        issue("imm_r1", 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 16'h1234);
        get_rsp("imm_r1", 16'h1234, 1'b0, 1, 1, 0);
        issue("rd_r1", 1'b0, 2'd2, 2'd3, 2'd1, 2'd0, 16'h0);
        check("rd_r1_ctrl", 32'(alu_ctrl), 32'd2);
        get_rsp("rd_r1", 16'h1234, 1'b0, ALU_LAT, 1, 0);

        // Carry-out wrap with operand stability through the settle window.
        issue("imm_ffff", 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 16'hFFFF);
        get_rsp("imm_ffff", 16'hFFFF, 1'b0, 1, 1, 0);
        issue("imm_0001", 1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 16'h0001);
        get_rsp("imm_0001", 16'h0001, 1'b0, 1, 1, 0);
        issue("add_wrap", 1'b0, 2'd0, 2'd3, 2'd1, 2'd2, 16'h0);
        for (int c = 0; c < ALU_WAIT + 1; c++) begin
            check("wrap_in1", 32'(alu_in1), 32'h0000FFFF);
            check("wrap_in2", 32'(alu_in2), 32'h00000001);
            check("wrap_ctrl", 32'(alu_ctrl), 32'd0);
            check("wrap_rv", 32'(rsp_valid), 32'd0);
            if (c < ALU_WAIT) tick();
        end
        get_rsp("add_wrap", 16'h0000, 1'b1, ALU_LAT, ALU_WAIT + 1, 0);

        // Back-pressure: consumer stalls five cycles.
        issue("stall", 1'b0, 2'd3, 2'd0, 2'd1, 2'd1, 16'h0);
        check("stall_ctrl", 32'(alu_ctrl), 32'd3);
        get_rsp("stall", 16'hFFFE, 1'b1, ALU_LAT, 1, 5);

        // Immediate loads leave the ALU operands untouched.
        issue("imm_3", 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 16'h0003);
        check("held_in1", 32'(alu_in1), 32'h0000FFFF);
        check("held_ctrl", 32'(alu_ctrl), 32'd3);
        get_rsp("imm_3", 16'h0003, 1'b0, 1, 1, 0);
        issue("imm_4", 1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 16'h0004);
        get_rsp("imm_4", 16'h0004, 1'b0, 1, 1, 0);

        // rd == rs1 reads the old value; the new one is visible afterwards.
        issue("rd_eq_rs1", 1'b0, 2'd1, 2'd1, 2'd1, 2'd2, 16'h0);
        check("rd_eq_rs1_in1", 32'(alu_in1), 32'h00000003);
        get_rsp("rd_eq_rs1", 16'h0007, 1'b0, ALU_LAT, 1, 0);
        issue("r1_new", 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 16'h0);
        check("r1_new_in1", 32'(alu_in1), 32'h00000007);
        get_rsp("r1_new", 16'h0005, 1'b1, ALU_LAT, 1, 0);

        // Reset during ISSUE aborts the command and clears the register file.
        issue("abort", 1'b0, 2'd0, 2'd3, 2'd1, 2'd2, 16'h0);
        check("abort_in1", 32'(alu_in1), 32'h00000007);
        rst = 1'b1;
        check("abort_rdy_rst", 32'(cmd_ready), 32'd0);
        tick();
        check("abort_in1_clr", 32'(alu_in1), 32'd0);
        check("abort_rdy", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
            check("abort_idle", 32'(cmd_ready), 32'd1);
        end
        issue("clr_r12", 1'b0, 2'd0, 2'd3, 2'd1, 2'd2, 16'h0);
        get_rsp("clr_r12", 16'h0000, 1'b0, ALU_LAT, 1, 0);
        issue("clr_r0", 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 16'h0);
        get_rsp("clr_r0", 16'h0000, 1'b0, ALU_LAT, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
